mont_mul_ctrl: RTL and testbench
================================

// Module: mont_mul_ctrl
// PURPOSE
//  Bit-serial Montgomery multiplier controller: computes R = A*B*2^-N mod M by
//  sequencing the shared multi-precision adder (start/done, subtract). Holds the
//  running accumulator C, issues add/sub jobs, performs the >>1 per bit locally,
//  and applies the final conditional subtraction. Sits between the RSA exponentiation
//  FSM and the adder instance.
// PARAMETERS
//  N      512    operand width in bits (A, B, M, R); adder operand width is N+2
// PORTS
//  clk           in   1      system clock
//  resetn        in   1      synchronous, active-low reset
//  start         in   1      one-cycle request; A/B/M sampled this cycle
//  in_a          in   N      multiplier A (scanned LSB first)
//  in_b          in   N      multiplicand B (< M)
//  in_m          in   N      odd modulus M
//  result        out  N      Montgomery product, valid from done until next start
//  done          out  1      one-cycle pulse: result valid
//  busy          out  1      high from cycle after start until done cycle inclusive
//  add_start     out  1      one-cycle pulse launching an adder job
//  add_subtract  out  1      0 = add, 1 = subtract; held stable for whole job
//  add_in_a      out  N+2    adder operand a (always C)
//  add_in_b      out  N+2    adder operand b (zero-extended B or M)
//  add_result    in   N+3    adder result, valid when add_done high
//  add_done      in   1      adder completion (level or pulse)
// BEHAVIOUR
//  Reset: all outputs 0, C=0, bit counter=0, state IDLE. Reset mid-job aborts
//   immediately; add_start low next cycle; late add_done ignored once IDLE.
//  Registers: a_sh (N, right-shifting), b_r, m_r (N), C (N+2), cnt (log2 N+1).
//  States/transitions:
//   IDLE:  start -> LOAD (latch A,B,M; C=0; cnt=0; busy=1). start while busy ignored.
//   CHK_A: a_sh[0]=1 -> ADD_B else CHK_ODD.
//   ADD_B: add_start=1, add_subtract=0, add_in_b=B -> WAIT_B.
//   WAIT_B: add_done -> C=add_result[N+1:0] -> CHK_ODD. add_done is not sampled in
//          the add_start cycle (stale done from a previous job is ignored).
//   CHK_ODD: C[0]=1 -> ADD_M else SHIFT.
//   ADD_M/WAIT_M: as ADD_B/WAIT_B with add_in_b=M.
//   SHIFT: C=C>>1; a_sh=a_sh>>1; cnt+1; cnt==N-1 -> SUB_M else CHK_A.
//   SUB_M: add_start=1, add_subtract=1, add_in_b=M -> WAIT_S.
//   WAIT_S: add_done: add_result[N+2]=1 (negative) -> result=C[N-1:0];
//          else result=add_result[N-1:0]. -> DONE.
//   DONE:  done=1 one cycle, busy=1 -> IDLE (busy=0).
//  Skipped additions (a_i=0 or C even) cost 1 cycle, never start the adder.
//  Invariant: C < 2M before each shift; C fits N+2 bits, add_result[N+2] never set
//   by additions. add_in_a/add_in_b/add_subtract held constant from add_start to add_done.
//  Latency (excl. adder): 3 + 3N + sum of job overheads; exactly one add_start per job;
//   total jobs = popcount-dependent adds + 1 final subtract.
//  A=0: no add jobs, one subtract job, result 0.
// TESTING (bench uses N=8 with a behavioural 1-cycle-done adder, plus N=512 smoke)
//  N=8, M=13, A=3, B=5 -> result=6, one done pulse, busy low next cycle.
//  N=8, M=13, A=1, B=1 -> result=3; add_start count = 1(B)+odd-driven M adds+1(sub).
//  N=8, M=13, A=0, B=7 -> result=0; exactly one add_start with add_subtract=1.
//  N=8, M=13, A=B=12 -> result=3; final subtraction path exercised (non-negative diff).
//  start pulsed again while busy, adder done delayed 5 cycles -> ignored, result
//   of first job unchanged; resetn low mid-WAIT_B -> outputs 0, IDLE, new start works.
//  N=512 random A,B<M odd -> result matches A*B*2^-512 mod M from python model.

Source files
------------

// File: rtl/mont_mul_ctrl.sv
// Bit-serial Montgomery multiplier controller: R = A*B*2^-N mod M, driving a
// shared multi-precision adder for the conditional add/subtract jobs.
module mont_mul_ctrl #(
  parameter int N = 512
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         add_start,
  output logic         add_subtract,
  output logic [N+1:0] add_in_a,
  output logic [N+1:0] add_in_b,
  input  logic [N+2:0] add_result,
  input  logic         add_done
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, CHK_A, ADD_B, WAIT_B, CHK_ODD, ADD_M, WAIT_M,
    SHIFT, SUB_M, WAIT_S, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_sh_q, a_sh_d;
  logic [N-1:0]    b_r_q, b_r_d;
  logic [N-1:0]    m_r_q, m_r_d;
  logic [N-1:0]    result_q, result_d;
  logic [N+1:0]    c_q, c_d;
  logic [N+1:0]    add_in_b_q, add_in_b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            add_start_q, add_start_d;
  logic            add_sub_q, add_sub_d;

  // A negative C-M means C was already reduced, so keep C itself.
  function automatic logic [N-1:0] final_sel(input logic         neg,
                                             input logic [N-1:0] c,
                                             input logic [N-1:0] diff);
    return neg ? c : diff;
  endfunction

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_r_d       = b_r_q;
    m_r_d       = m_r_q;
    result_d    = result_q;
    c_d         = c_q;
    add_in_b_d  = add_in_b_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    add_start_d = 1'b0;
    add_sub_d   = add_sub_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = in_a;
          b_r_d   = in_b;
          m_r_d   = in_m;
          c_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = CHK_A;
      CHK_A: begin
        if (a_sh_q[0]) begin
          add_start_d = 1'b1;
          add_sub_d   = 1'b0;
          add_in_b_d  = {2'b00, b_r_q};
          state_d     = ADD_B;
        end else begin
          state_d = CHK_ODD;
        end
      end
      // add_start is high during ADD_x/SUB_M; add_done is only sampled in WAIT_x
      ADD_B: state_d = WAIT_B;
      WAIT_B: begin
        if (add_done) begin
          c_d     = add_result[N+1:0];
          state_d = CHK_ODD;
        end
      end
      CHK_ODD: begin
        if (c_q[0]) begin
          add_start_d = 1'b1;
          add_sub_d   = 1'b0;
          add_in_b_d  = {2'b00, m_r_q};
          state_d     = ADD_M;
        end else begin
          state_d = SHIFT;
        end
      end
      ADD_M: state_d = WAIT_M;
      WAIT_M: begin
        if (add_done) begin
          c_d     = add_result[N+1:0];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        c_d    = c_q >> 1;
        a_sh_d = a_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          add_start_d = 1'b1;
          add_sub_d   = 1'b1;
          add_in_b_d  = {2'b00, m_r_q};
          state_d     = SUB_M;
        end else begin
          state_d = CHK_A;
        end
      end
      SUB_M: state_d = WAIT_S;
      WAIT_S: begin
        if (add_done) begin
          result_d = final_sel(add_result[N+2], c_q[N-1:0], add_result[N-1:0]);
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    a_sh_q <= a_sh_d;
    b_r_q  <= b_r_d;
    m_r_q  <= m_r_d;
    if (!resetn) begin
      state_q     <= IDLE;
      result_q    <= '0;
      c_q         <= '0;
      add_in_b_q  <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      add_start_q <= 1'b0;
      add_sub_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      c_q         <= c_d;
      add_in_b_q  <= add_in_b_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      add_start_q <= add_start_d;
      add_sub_q   <= add_sub_d;
    end
  end

  assign result       = result_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign add_start    = add_start_q;
  assign add_subtract = add_sub_q;
  assign add_in_a     = c_q;
  assign add_in_b     = add_in_b_q;

endmodule

// File: tb/tb_mont_mul_ctrl.sv
// Bench for mont_mul_ctrl: N=8 instance with a delay-programmable adder model,
// plus an N=512 instance checked by modular congruence.
module tb_mont_mul_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  logic        start8, done8, busy8, ast8, asub8, adone8;
  logic [7:0]  a8, b8, m8, res8;
  logic [9:0]  ain8, bin8;
  logic [10:0] ares8;

  logic         startb, doneb, busyb, astb, asubb, adoneb;
  logic [511:0] ab, bb, mb, resb;
  logic [513:0] ainb, binb;
  logic [514:0] aresb;

  mont_mul_ctrl #(.N(8)) dut8 (
    .clk(clk), .resetn(resetn), .start(start8), .in_a(a8), .in_b(b8), .in_m(m8),
    .result(res8), .done(done8), .busy(busy8), .add_start(ast8),
    .add_subtract(asub8), .add_in_a(ain8), .add_in_b(bin8),
    .add_result(ares8), .add_done(adone8)
  );

  mont_mul_ctrl #(.N(512)) dutb (
    .clk(clk), .resetn(resetn), .start(startb), .in_a(ab), .in_b(bb), .in_m(mb),
    .result(resb), .done(doneb), .busy(busyb), .add_start(astb),
    .add_subtract(asubb), .add_in_a(ainb), .add_in_b(binb),
    .add_result(aresb), .add_done(adoneb)
  );

  // Behavioural adder for the N=8 instance; latency set by dly8, ignores resetn.
  int         dly8 = 1;
  int         starts8 = 0, subs8 = 0, dones8 = 0, stab8 = 0, dcnt8 = 0;
  logic       pend8 = 1'b0;
  logic [9:0] ca8 = '0, cb8 = '0;
  logic       csub8 = 1'b0;

  always @(posedge clk) begin
    adone8 <= 1'b0;
    if (done8) dones8 <= dones8 + 1;
    if (ast8) begin
      starts8 <= starts8 + 1;
      if (asub8) subs8 <= subs8 + 1;
      ca8 <= ain8; cb8 <= bin8; csub8 <= asub8;
      if (dly8 <= 1) begin
        adone8 <= 1'b1;
        ares8  <= asub8 ? {1'b0, ain8} - {1'b0, bin8} : {1'b0, ain8} + {1'b0, bin8};
        pend8  <= 1'b0;
      end else begin
        pend8 <= 1'b1;
        dcnt8 <= dly8 - 1;
      end
    end else if (pend8) begin
      if (busy8 && (ain8 !== ca8 || bin8 !== cb8 || asub8 !== csub8)) stab8 <= stab8 + 1;
      if (dcnt8 <= 1) begin
        adone8 <= 1'b1;
        pend8  <= 1'b0;
        ares8  <= csub8 ? {1'b0, ca8} - {1'b0, cb8} : {1'b0, ca8} + {1'b0, cb8};
      end else begin
        dcnt8 <= dcnt8 - 1;
      end
    end
  end

  always @(posedge clk) begin
    adoneb <= 1'b0;
    if (astb) begin
      adoneb <= 1'b1;
      aresb  <= asubb ? {1'b0, ainb} - {1'b0, binb} : {1'b0, ainb} + {1'b0, binb};
    end
  end

  int n_cmp = 0, n_mis = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Montgomery product by definition: the x < m with x*2^8 == a*b (mod m).
  function automatic int ref8(input int a, input int b, input int m);
    int t;
    t = (a * b) % m;
    for (int x = 0; x < m; x++)
      if (((x << 8) % m) == t) return x;
    return -1;
  endfunction

  // Adder jobs the interleaved reduction needs: one per set A bit, one per odd
  // partial sum, plus the final subtraction.
  function automatic int jobs8(input int a, input int b, input int m);
    int c, j;
    c = 0; j = 1;
    for (int i = 0; i < 8; i++) begin
      if (((a >> i) & 1) == 1) begin c += b; j++; end
      if ((c & 1) == 1) begin c += m; j++; end
      c = c / 2;
    end
    return j;
  endfunction

  task automatic run8(input int a, input int b, input int m, input string tag);
    int s0, u0, d0, st0, cyc;
    s0 = starts8; u0 = subs8; d0 = dones8; st0 = stab8;
    @(posedge clk); #1;
    a8 = 8'(a); b8 = 8'(b); m8 = 8'(m); start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk({tag, "_busy"}, 512'(busy8), 512'd1);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    chk({tag, "_timeout"}, 512'(cyc < 3000), 512'd1);
    chk({tag, "_res"}, 512'(res8), 512'(ref8(a, b, m)));
    @(posedge clk); #1;
    chk({tag, "_busy_off"}, 512'(busy8), 512'd0);
    chk({tag, "_done_off"}, 512'(done8), 512'd0);
    chk({tag, "_res_hold"}, 512'(res8), 512'(ref8(a, b, m)));
    chk({tag, "_ndone"}, 512'(dones8 - d0), 512'd1);
    chk({tag, "_jobs"}, 512'(starts8 - s0), 512'(jobs8(a, b, m)));
    chk({tag, "_subs"}, 512'(subs8 - u0), 512'd1);
    chk({tag, "_stable"}, 512'(stab8 - st0), 512'd0);
  endtask

  initial begin
    int cyc, d0, s0, u0, a, b, m;
    logic [511:0]  rb;
    logic [1023:0] t, e, mm, tmp;

    resetn = 1'b0; start8 = 1'b0; startb = 1'b0;
    a8 = '0; b8 = '0; m8 = '0; ab = '0; bb = '0; mb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res", 512'(res8), 512'd0);
    chk("rst_done", 512'(done8), 512'd0);
    chk("rst_busy", 512'(busy8), 512'd0);
    chk("rst_ast", 512'(ast8), 512'd0);
    chk("rst_asub", 512'(asub8), 512'd0);
    chk("rst_ain", 512'(ain8), 512'd0);
    chk("rst_bin", 512'(bin8), 512'd0);
    chk("rst_busy_b", 512'(busyb), 512'd0);
    resetn = 1'b1;

    dly8 = 1;
    run8(3, 5, 13, "a3b5");
    chk("a3b5_lit", 512'(res8), 512'd6);
    run8(1, 1, 13, "a1b1");
    chk("a1b1_lit", 512'(res8), 512'd3);
    s0 = starts8; u0 = subs8;
    run8(0, 7, 13, "a0b7");
    chk("a0b7_lit", 512'(res8), 512'd0);
    chk("a0b7_starts", 512'(starts8 - s0), 512'd1);
    chk("a0b7_subonly", 512'(subs8 - u0), 512'd1);
    run8(12, 12, 13, "a12b12");
    chk("a12b12_lit", 512'(res8), 512'd3);

    // second start while busy, slow adder
    dly8 = 5;
    d0 = dones8;
    @(posedge clk); #1;
    a8 = 8'd3; b8 = 8'd5; m8 = 8'd13; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    a8 = 8'd12; b8 = 8'd12; m8 = 8'd11; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    chk("busy_start_timeout", 512'(cyc < 3000), 512'd1);
    chk("busy_start_res", 512'(res8), 512'd6);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_start_ndone", 512'(dones8 - d0), 512'd1);
    chk("busy_start_idle", 512'(busy8), 512'd0);

    // reset in the middle of WAIT_B
    @(posedge clk); #1;
    a8 = 8'd255; b8 = 8'd5; m8 = 8'd13; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 0;
    while (ast8 !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("rst_mid_reach", 512'(cyc < 50), 512'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("rst_mid_busy", 512'(busy8), 512'd0);
    chk("rst_mid_ast", 512'(ast8), 512'd0);
    chk("rst_mid_res", 512'(res8), 512'd0);
    chk("rst_mid_ain", 512'(ain8), 512'd0);
    d0 = dones8; s0 = starts8;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_nodone", 512'(dones8 - d0), 512'd0);
    chk("rst_mid_nostart", 512'(starts8 - s0), 512'd0);
    chk("rst_mid_idle", 512'(busy8), 512'd0);
    run8(3, 5, 13, "post_rst");

    for (int k = 0; k < 20; k++) begin
      m = int'($urandom_range(3, 255)) | 1;
      b = int'($urandom_range(0, m - 1));
      a = int'($urandom_range(0, 255));
      dly8 = int'($urandom_range(1, 3));
      run8(a, b, m, "rnd8");
    end

    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++) begin
        mb[w*32 +: 32] = $urandom;
        ab[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      mb[511] = 1'b1; mb[0] = 1'b1;
      mm  = {512'd0, mb};
      tmp = {512'd0, rb} % mm;
      bb  = tmp[511:0];
      @(posedge clk); #1;
      startb = 1'b1;
      @(posedge clk); #1;
      startb = 1'b0;
      cyc = 0;
      while (doneb !== 1'b1 && cyc < 20000) begin @(posedge clk); #1; cyc++; end
      chk("big_timeout", 512'(cyc < 20000), 512'd1);
      t = {resb, 512'd0} % mm;
      e = ({512'd0, ab} * {512'd0, bb}) % mm;
      chk("big_congruent", t[511:0], e[511:0]);
      chk("big_reduced", 512'(resb < mb), 512'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
